// File: rtl/nn_layer_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the 10-5-3 MLP layer sequencer: network dimensions,
// weight-memory layout bases and the FSM state encoding (the encoding is
// exported on the debug state port, so the numeric codes are fixed).
// -----------------------------------------------------------------------------
package nn_pkg;

    localparam int N_IN     = 10;
    localparam int N_HID    = 5;
    localparam int N_OUT    = 3;
    localparam int ADDR_W   = 7;

    // Hidden-layer weights sit first in memory, output-layer weights follow.
    localparam int HID_BASE = 0;
    localparam int OUT_BASE = N_IN * N_HID;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_H_CLR   = 4'd2,
        ST_H_MAC   = 4'd3,
        ST_H_DRAIN = 4'd4,
        ST_H_STORE = 4'd5,
        ST_O_CLR   = 4'd6,
        ST_O_MAC   = 4'd7,
        ST_O_DRAIN = 4'd8,
        ST_O_STORE = 4'd9,
        ST_DONE    = 4'd10
    } state_e;

    // True in the states that issue a weight read to the MAC.
    function automatic logic is_mac_state(input state_e s);
        return (s == ST_H_MAC) || (s == ST_O_MAC);
    endfunction

    // True in the states that belong to the output-layer pass.
    function automatic logic is_out_layer(input state_e s);
        return (s == ST_O_CLR) || (s == ST_O_MAC) || (s == ST_O_DRAIN) || (s == ST_O_STORE);
    endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// -----------------------------------------------------------------------------
// nn_layer_sequencer_if
// Control/debug bundle between the top-level controller and the sequencer.
//   master : drives i_in (inference request), i_we (weight load), i_ld_addr
//   slave  : the sequencer; drives weight address, MAC strobes, debug state
// -----------------------------------------------------------------------------
interface nn_layer_sequencer_if #(
    parameter int ADDR_W = 7
);
    logic              i_in;
    logic              i_we;
    logic [ADDR_W-1:0] i_ld_addr;

    logic [ADDR_W-1:0] o_address;
    logic [3:0]        o_state;
    logic [3:0]        o_in_sel;
    logic              o_mac_clr;
    logic              o_mac_en;
    logic [3:0]        o_mac_idx;
    logic              o_layer;
    logic [2:0]        o_neuron_idx;
    logic              o_hid_wr;
    logic              o_out_wr;
    logic              o_busy;
    logic              o_done;

    modport master (
        output i_in, i_we, i_ld_addr,
        input  o_address, o_state, o_in_sel, o_mac_clr, o_mac_en, o_mac_idx,
               o_layer, o_neuron_idx, o_hid_wr, o_out_wr, o_busy, o_done
    );

    modport slave (
        input  i_in, i_we, i_ld_addr,
        output o_address, o_state, o_in_sel, o_mac_clr, o_mac_en, o_mac_idx,
               o_layer, o_neuron_idx, o_hid_wr, o_out_wr, o_busy, o_done
    );
endinterface

// File: rtl/nn_layer_sequencer_addr_gen.sv
// -----------------------------------------------------------------------------
// nn_addr_gen
// Combinational weight address: base + neuron * stride + j.
// The hidden pass uses stride N_IN from base 0, the output pass uses stride
// N_HID from base N_IN*N_HID.
//   i_layer  : 0 hidden pass, 1 output pass
//   i_neuron : neuron currently computed
//   i_j      : operand index within the neuron
//   o_addr   : weight-memory address
// -----------------------------------------------------------------------------
module nn_addr_gen
    import nn_pkg::*;
#(
    parameter int P_N_IN   = nn_pkg::N_IN,
    parameter int P_N_HID  = nn_pkg::N_HID,
    parameter int P_ADDR_W = nn_pkg::ADDR_W
) (
    input  logic                i_layer,
    input  logic [2:0]          i_neuron,
    input  logic [3:0]          i_j,
    output logic [P_ADDR_W-1:0] o_addr
);

    localparam logic [P_ADDR_W-1:0] HID_BASE_A   = P_ADDR_W'(HID_BASE);
    localparam logic [P_ADDR_W-1:0] OUT_BASE_A   = P_ADDR_W'(P_N_IN * P_N_HID);
    localparam logic [P_ADDR_W-1:0] HID_STRIDE_A = P_ADDR_W'(P_N_IN);
    localparam logic [P_ADDR_W-1:0] OUT_STRIDE_A = P_ADDR_W'(P_N_HID);

    logic [P_ADDR_W-1:0] w_base;
    logic [P_ADDR_W-1:0] w_stride;
    logic [P_ADDR_W-1:0] w_offset;

    // Select layer geometry and form the flat weight index.
    always_comb begin
        if (i_layer) begin
            w_base   = OUT_BASE_A;
            w_stride = OUT_STRIDE_A;
        end else begin
            w_base   = HID_BASE_A;
            w_stride = HID_STRIDE_A;
        end
        w_offset = w_stride * P_ADDR_W'(i_neuron);
        o_addr   = w_base + w_offset + P_ADDR_W'(i_j);
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// nn_layer_sequencer
// Control sequencer for the 10-5-3 fixed-point MLP datapath. Walks the shared
// weight memory one weight per cycle, drives MAC clear/enable and operand
// select, strobes finished sums into hidden/output registers, and hands the
// weight address to the external loader while WE is held in IDLE/LOAD.
//   i_clk    : system clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   bus      : slave side of nn_layer_sequencer_if (requests in, strobes and
//              debug state/address out)
// -----------------------------------------------------------------------------
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int P_N_IN   = nn_pkg::N_IN,
    parameter int P_N_HID  = nn_pkg::N_HID,
    parameter int P_N_OUT  = nn_pkg::N_OUT,
    parameter int P_ADDR_W = nn_pkg::ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    nn_layer_sequencer_if.slave   bus
);

    localparam logic [3:0] J_LAST_H = 4'(P_N_IN - 1);
    localparam logic [3:0] J_LAST_O = 4'(P_N_HID - 1);
    localparam logic [2:0] N_LAST_H = 3'(P_N_HID - 1);
    localparam logic [2:0] N_LAST_O = 3'(P_N_OUT - 1);

    state_e                r_state;
    state_e                w_next_state;
    logic [2:0]            r_neuron;
    logic [2:0]            w_next_neuron;
    logic [3:0]            r_j;
    logic [3:0]            w_next_j;
    logic                  r_mac_en;
    logic [3:0]            r_mac_idx;

    logic                  w_is_mac;
    logic                  w_layer;
    logic [3:0]            w_in_sel;
    logic [P_ADDR_W-1:0]   w_gen_addr;
    logic [P_ADDR_W-1:0]   w_address;

    nn_addr_gen #(
        .P_N_IN   (P_N_IN),
        .P_N_HID  (P_N_HID),
        .P_ADDR_W (P_ADDR_W)
    ) u_addr_gen (
        .i_layer  (w_layer),
        .i_neuron (r_neuron),
        .i_j      (r_j),
        .o_addr   (w_gen_addr)
    );

    // FSM state, neuron and operand counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_neuron <= 3'd0;
            r_j      <= 4'd0;
        end else begin
            r_state  <= w_next_state;
            r_neuron <= w_next_neuron;
            r_j      <= w_next_j;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        w_next_state  = r_state;
        w_next_neuron = r_neuron;
        w_next_j      = r_j;
        case (r_state)
            ST_IDLE: begin
                // WE wins over In so a loader is never starved.
                if (bus.i_we) begin
                    w_next_state = ST_LOAD;
                end else if (bus.i_in) begin
                    w_next_state  = ST_H_CLR;
                    w_next_neuron = 3'd0;
                    w_next_j      = 4'd0;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.i_we) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_H_CLR: begin
                w_next_state = ST_H_MAC;
                w_next_j     = 4'd0;
            end
            ST_H_MAC: begin
                if (r_j == J_LAST_H) begin
                    w_next_state = ST_H_DRAIN;
                    w_next_j     = 4'd0;
                end else begin
                    w_next_j = r_j + 4'd1;
                end
            end
            ST_H_DRAIN: begin
                w_next_state = ST_H_STORE;
            end
            ST_H_STORE: begin
                if (r_neuron == N_LAST_H) begin
                    w_next_state  = ST_O_CLR;
                    w_next_neuron = 3'd0;
                end else begin
                    w_next_state  = ST_H_CLR;
                    w_next_neuron = r_neuron + 3'd1;
                end
            end
            ST_O_CLR: begin
                w_next_state = ST_O_MAC;
                w_next_j     = 4'd0;
            end
            ST_O_MAC: begin
                if (r_j == J_LAST_O) begin
                    w_next_state = ST_O_DRAIN;
                    w_next_j     = 4'd0;
                end else begin
                    w_next_j = r_j + 4'd1;
                end
            end
            ST_O_DRAIN: begin
                w_next_state = ST_O_STORE;
            end
            ST_O_STORE: begin
                if (r_neuron == N_LAST_O) begin
                    w_next_state  = ST_DONE;
                    w_next_neuron = 3'd0;
                end else begin
                    w_next_state  = ST_O_CLR;
                    w_next_neuron = r_neuron + 3'd1;
                end
            end
            ST_DONE: begin
                // Always passes through IDLE before the next launch.
                w_next_state  = ST_IDLE;
                w_next_neuron = 3'd0;
                w_next_j      = 4'd0;
            end
            default: begin
                w_next_state  = ST_IDLE;
                w_next_neuron = 3'd0;
                w_next_j      = 4'd0;
            end
        endcase
    end

    // Output decode from the current state; address is muxed between loader and generator.
    always_comb begin
        w_is_mac = is_mac_state(r_state);
        w_layer  = is_out_layer(r_state);
        if (w_is_mac) begin
            w_in_sel = r_j;
        end else begin
            w_in_sel = 4'd0;
        end
        if (r_state == ST_LOAD) begin
            w_address = bus.i_ld_addr;
        end else if (w_is_mac) begin
            w_address = w_gen_addr;
        end else begin
            w_address = {P_ADDR_W{1'b0}};
        end
    end

    // One-cycle delay matching the weight memory read latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mac_en  <= 1'b0;
            r_mac_idx <= 4'd0;
        end else begin
            r_mac_en  <= w_is_mac;
            r_mac_idx <= w_in_sel;
        end
    end

    assign bus.o_address    = w_address;
    assign bus.o_state      = r_state;
    assign bus.o_in_sel     = w_in_sel;
    assign bus.o_mac_clr    = (r_state == ST_H_CLR) || (r_state == ST_O_CLR);
    assign bus.o_mac_en     = r_mac_en;
    assign bus.o_mac_idx    = r_mac_idx;
    assign bus.o_layer      = w_layer;
    assign bus.o_neuron_idx = r_neuron;
    assign bus.o_hid_wr     = (r_state == ST_H_STORE);
    assign bus.o_out_wr     = (r_state == ST_O_STORE);
    assign bus.o_busy       = (r_state != ST_IDLE) && (r_state != ST_LOAD);
    assign bus.o_done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nn_layer_sequencer
// Self-checking bench: a cycle-list model of one inference (built from the
// layer loops) predicts every output each cycle; directed sections pin the
// model with literal expectations; a random phase exercises In/WE/reset.
// -----------------------------------------------------------------------------
module tb_nn_layer_sequencer;

    localparam int AW = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    nn_layer_sequencer_if #(.ADDR_W(AW)) bus ();

    nn_layer_sequencer dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int st; int addr; int sel; int nidx; int lay;
        bit clr; bit mac; bit hw; bit ow; bit dn;
    } rec_t;

    rec_t q[$];
    int   m_mode     = 0;   // 0 idle, 1 load, 2 running an inference
    bit   m_prev_mac = 0;
    int   m_prev_sel = 0;

    function automatic rec_t mk(int st, int addr, int sel, int nidx, int lay,
                                bit clr, bit mac, bit hw, bit ow, bit dn);
        rec_t r;
        r.st = st; r.addr = addr; r.sel = sel; r.nidx = nidx; r.lay = lay;
        r.clr = clr; r.mac = mac; r.hw = hw; r.ow = ow; r.dn = dn;
        return r;
    endfunction

    // One inference as an explicit list of cycles, first entry = first busy cycle.
    function automatic void build_run();
        q.delete();
        for (int n = 0; n < 5; n++) begin
            q.push_back(mk(2, 0, 0, n, 0, 1, 0, 0, 0, 0));
            for (int j = 0; j < 10; j++) q.push_back(mk(3, n * 10 + j, j, n, 0, 0, 1, 0, 0, 0));
            q.push_back(mk(4, 0, 0, n, 0, 0, 0, 0, 0, 0));
            q.push_back(mk(5, 0, 0, n, 0, 0, 0, 1, 0, 0));
        end
        for (int n = 0; n < 3; n++) begin
            q.push_back(mk(6, 0, 0, n, 1, 1, 0, 0, 0, 0));
            for (int j = 0; j < 5; j++) q.push_back(mk(7, 50 + n * 5 + j, j, n, 1, 0, 1, 0, 0, 0));
            q.push_back(mk(8, 0, 0, n, 1, 0, 0, 0, 0, 0));
            q.push_back(mk(9, 0, 0, n, 1, 0, 0, 0, 1, 0));
        end
        q.push_back(mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = 0; q.delete(); m_prev_mac = 0; m_prev_sel = 0;
        end else begin
            if (m_mode == 2) begin
                m_prev_mac = q[0].mac; m_prev_sel = q[0].sel;
            end else begin
                m_prev_mac = 0; m_prev_sel = 0;
            end
            case (m_mode)
                0: begin
                    if (bus.i_we) m_mode = 1;
                    else if (bus.i_in) begin build_run(); m_mode = 2; end
                end
                1: if (!bus.i_we) m_mode = 0;
                default: begin
                    void'(q.pop_front());
                    if (q.size() == 0) m_mode = 0;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial forever begin
        rec_t e;
        int   e_busy;
        @(negedge clk);
        e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_busy = 0;
        if (rst_n && m_mode == 1) begin
            e.st = 1; e.addr = int'(bus.i_ld_addr);
        end else if (rst_n && m_mode == 2) begin
            e = q[0]; e_busy = 1;
        end
        chk("state",   32'(bus.o_state),      e.st);
        chk("address", 32'(bus.o_address),    e.addr);
        chk("in_sel",  32'(bus.o_in_sel),     e.sel);
        chk("neuron",  32'(bus.o_neuron_idx), e.nidx);
        chk("layer",   32'(bus.o_layer),      e.lay);
        chk("mac_clr", 32'(bus.o_mac_clr),    32'(e.clr));
        chk("hid_wr",  32'(bus.o_hid_wr),     32'(e.hw));
        chk("out_wr",  32'(bus.o_out_wr),     32'(e.ow));
        chk("done",    32'(bus.o_done),       32'(e.dn));
        chk("busy",    32'(bus.o_busy),       e_busy);
        chk("mac_en",  32'(bus.o_mac_en),     32'(rst_n && m_prev_mac));
        chk("mac_idx", 32'(bus.o_mac_idx),    rst_n ? m_prev_sel : 0);
        chk("clr_en_excl", 32'(bus.o_mac_clr & bus.o_mac_en), 0);
    end

    // ---------------- directed-section monitor ----------------
    bit mon_on   = 0;
    int mac_cnt  = 0;
    int done_cnt = 0;
    int hw_idx[$];
    int ow_idx[$];
    int addr_seq[$];

    initial forever begin
        @(negedge clk);
        if (bus.o_done === 1'b1) done_cnt++;
        if (mon_on) begin
            if (bus.o_mac_en === 1'b1) mac_cnt++;
            if (bus.o_hid_wr === 1'b1) hw_idx.push_back(int'(bus.o_neuron_idx));
            if (bus.o_out_wr === 1'b1) ow_idx.push_back(int'(bus.o_neuron_idx));
            if (bus.o_state == 4'd3 || bus.o_state == 4'd7) addr_seq.push_back(int'(bus.o_address));
        end
    end

    // Counts negedges until done is seen; bounded.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.o_done !== 1'b1 && n < 300);
    endtask

    task automatic run_single(input string tag);
        int n;
        mac_cnt = 0; hw_idx.delete(); ow_idx.delete(); addr_seq.delete();
        mon_on = 1;
        @(posedge clk); #1 bus.i_in = 1'b1;
        @(posedge clk); #1 bus.i_in = 1'b0;
        wait_done(n);
        chk({tag, "_done_lat"}, n, 90);
        @(negedge clk); @(negedge clk);
        mon_on = 0;
        chk({tag, "_mac_cnt"}, mac_cnt, 65);
        chk({tag, "_hw_cnt"}, hw_idx.size(), 5);
        chk({tag, "_ow_cnt"}, ow_idx.size(), 3);
        chk({tag, "_addr_cnt"}, addr_seq.size(), 65);
        foreach (hw_idx[i]) chk({tag, "_hw_idx"}, hw_idx[i], i);
        foreach (ow_idx[i]) chk({tag, "_ow_idx"}, ow_idx[i], i);
        foreach (addr_seq[i]) chk({tag, "_addr_seq"}, addr_seq[i], i);
    endtask

    initial begin
        int n;
        int dc;
        bus.i_in = 1'b0; bus.i_we = 1'b0; bus.i_ld_addr = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_state", 32'(bus.o_state), 0);
        chk("rst_addr", 32'(bus.o_address), 0);
        chk("rst_busy", 32'(bus.o_busy), 0);

        // Single inference
        run_single("single");

        // Arbitration: WE and In together -> LOAD, address follows loader
        @(posedge clk); #1 bus.i_in = 1'b1; bus.i_we = 1'b1; bus.i_ld_addr = 7'h3F;
        @(posedge clk); #1;
        chk("arb_state", 32'(bus.o_state), 1);
        chk("arb_addr", 32'(bus.o_address), 32'h3F);
        bus.i_ld_addr = 7'h12;
        #1 chk("arb_addr_comb", 32'(bus.o_address), 32'h12);
        repeat (2) @(posedge clk);
        #1 chk("arb_in_ignored", 32'(bus.o_state), 1);
        bus.i_we = 1'b0;
        @(posedge clk); #1 chk("arb_idle_gap", 32'(bus.o_state), 0);
        @(posedge clk); #1 chk("arb_launch", 32'(bus.o_state), 2);

        // Back-to-back with In held high
        wait_done(n);
        chk("b2b_first", n, 90);
        wait_done(n);
        chk("b2b_period", n, 91);
        repeat (20) @(negedge clk);
        bus.i_we = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("we_busy_ignored", 32'(bus.o_state == 4'd1), 0);
        end
        wait_done(n);
        chk("b2b_third", n, 61);
        @(posedge clk); #1 chk("post_done_idle", 32'(bus.o_state), 0);
        @(posedge clk); #1 chk("post_done_load", 32'(bus.o_state), 1);
        bus.i_in = 1'b0; bus.i_we = 1'b0;
        @(posedge clk); #1 chk("load_exit", 32'(bus.o_state), 0);

        // Reset during H_MAC of neuron 2
        @(posedge clk); #1 bus.i_in = 1'b1;
        @(posedge clk); #1 bus.i_in = 1'b0;
        repeat (30) @(negedge clk);
        chk("pre_rst_state", 32'(bus.o_state), 3);
        chk("pre_rst_neuron", 32'(bus.o_neuron_idx), 2);
        dc = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(bus.o_state), 0);
        chk("async_rst_addr", 32'(bus.o_address), 0);
        chk("async_rst_busy", 32'(bus.o_busy), 0);
        chk("async_rst_neuron", 32'(bus.o_neuron_idx), 0);
        chk("async_rst_mac_en", 32'(bus.o_mac_en), 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("rst_no_done", done_cnt, dc);
        run_single("rerun");

        // Random phase
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            bus.i_in = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) bus.i_we = ~bus.i_we;
            bus.i_ld_addr = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 799) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        bus.i_in = 1'b0; bus.i_we = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("final_idle", 32'(bus.o_state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
Control sequencer for the 10-5-3 fixed-point MLP datapath (hidden layer plus output layer).
- Walks the shared weight memory one weight per cycle and drives MAC clear/enable and operand-select strobes.
- Strobes each finished neuron sum into the hidden or output activation registers.
- Arbitrates the weight-memory address between inference and external weight loading (WE).
- Sits between the top-level control inputs (In, WE) and the HiddenLayer datapath; exposes state and address for debug.

Parameters:
N_IN, 10, input features per inference
N_HID, 5, hidden neurons
N_OUT, 3, output neurons
ADDR_W, 7, weight-memory address width; N_IN*N_HID + N_HID*N_OUT must be <= 2**ADDR_W

Ports:
Clock  in  1  system clock, rising edge
Rst  in  1  asynchronous active-low reset
In  in  1  inference request, level; sampled only in IDLE
WE  in  1  weight-load request, level; sampled only in IDLE/LOAD
ld_addr  in  ADDR_W  loader address, passed through during LOAD
address  out  ADDR_W  weight-memory read/write address
state  out  4  current FSM state encoding
in_sel  out  4  operand index issued with address (input j or hidden j)
mac_clr  out  1  clear accumulator
mac_en  out  1  accumulate; aligned with weight data (1-cycle memory latency)
mac_idx  out  4  in_sel delayed 1 cycle, valid with mac_en
layer  out  1  0 = hidden pass, 1 = output pass (selects operand source)
neuron_idx  out  3  neuron currently computed
hid_wr  out  1  store activated sum into hidden register neuron_idx
out_wr  out  1  store sum into output register neuron_idx
busy  out  1  high in every state except IDLE and LOAD
done  out  1  one-cycle pulse at end of inference

Behaviour:
- Reset (Rst=0, async): state=IDLE; all outputs 0; counters 0. An in-flight inference is abandoned with no done pulse.
- State encoding: IDLE=0, LOAD=1, H_CLR=2, H_MAC=3, H_DRAIN=4, H_STORE=5, O_CLR=6, O_MAC=7, O_DRAIN=8, O_STORE=9, DONE=10. Codes 11-15 return to IDLE next cycle.
- IDLE: if WE -> LOAD (WE has priority over In); else if In -> H_CLR with neuron_idx=0.
- LOAD: address=ld_addr combinationally; stays while WE=1; WE=0 -> IDLE. In is ignored in LOAD.
- H_CLR: mac_clr=1, layer=0; in_sel counter j=0.
- H_MAC: N_IN cycles; address = neuron_idx*N_IN + j; in_sel=j; j increments; after j=N_IN-1 -> H_DRAIN.
- mac_en / mac_idx: registered copy of (H_MAC|O_MAC, in_sel), so mac_en is high from the 2nd MAC cycle through the DRAIN cycle (exactly N_IN or N_HID cycles).
- H_STORE: hid_wr=1 for one cycle. If neuron_idx=N_HID-1 -> O_CLR with neuron_idx=0; else neuron_idx++ -> H_CLR.
- Output pass: mirrors the hidden pass with N_HID operands, layer=1, address = N_IN*N_HID + neuron_idx*N_HID + j, out_wr in O_STORE. After the last output neuron -> DONE.
- DONE: done=1 for one cycle -> IDLE. At least one IDLE cycle always precedes the next launch.
- Cycle budget per inference (defaults):
  - hidden neuron: 1 CLR + 10 MAC + 1 DRAIN + 1 STORE = 13 cycles; 5 neurons = 65 cycles
  - output neuron: 1 + 5 + 1 + 1 = 8 cycles; 3 neurons = 24 cycles
  - done is high in the 90th cycle after the edge that accepted In.
- WE or a change of In while busy: ignored; no preemption.
- address=0 in IDLE, CLR, DRAIN, STORE and DONE.

Decomposition:
- Package nn_pkg: state enum typedef; N_IN, N_HID, N_OUT, ADDR_W defaults; HID_BASE=0; OUT_BASE=N_IN*N_HID.
- Optional sub-module nn_addr_gen: combinational address = base + neuron_idx*stride + j. It is natural because the stride multiply differs per layer.
- The FSM and the mac_en/mac_idx delay register stay in the top module.

Test Plan:
- Reset values: assert Rst=0 mid-sim -> all outputs 0, state=0 immediately, without waiting for a clock edge.
- Single inference: In=1 for one cycle in IDLE -> address sequence 0..49 then 50..64, each value exactly once, in order. Also check:
  - 5 hid_wr pulses with neuron_idx 0..4, then 3 out_wr pulses with neuron_idx 0..2
  - done high exactly 90 cycles after acceptance
  - mac_en count = 65
- Alignment: every mac_en cycle has mac_idx equal to the in_sel issued the previous cycle; mac_clr is never high together with mac_en.
- Arbitration: WE=1 and In=1 together in IDLE -> state=1 and address tracks ld_addr (e.g. 0x3F). Drop WE -> IDLE for 1 cycle, then H_CLR.
- Back-to-back: In held high -> done pulses every 91 cycles. Raising WE while busy has no effect until after done.
- Reset mid-op: Rst low during H_MAC of neuron 2 -> IDLE, no done. Rerun with In -> address restarts at 0 and the full 90-cycle sequence repeats.
